// File: rtl/dff_rv_pkg.sv
// ============================================================================
// Module : dff_rv_pkg
// Brief  : Shared width limit and reset-value type for the dff_rv register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

package dff_rv_pkg;

    localparam int DFF_RV_MAX_W = 64;

    typedef logic [DFF_RV_MAX_W-1:0] dff_rv_val_t;

endpackage : dff_rv_pkg

`default_nettype wire

// File: rtl/dff_rv_bit.sv
// ============================================================================
// Module : dff_rv_bit
// Brief  : Single-bit enabled flop with per-bit reset value; optional scan
//          input selected by DFF_RV_SCAN_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module dff_rv_bit #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic d_i,
`ifdef DFF_RV_SCAN_EN
    input  logic scan_en_i,
    input  logic q_i,
`endif
    output logic q_o
);

    logic bit_q;
    logic bit_d;

    // Scan outranks the functional enable; reset outranks both in the flop.
    always_comb begin
        bit_d = bit_q;
`ifdef DFF_RV_SCAN_EN
        if (scan_en_i) begin
            bit_d = q_i;
        end else if (en_i) begin
            bit_d = d_i;
        end
`else
        if (en_i) begin
            bit_d = d_i;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bit_q <= RESET_VAL;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q_o = bit_q;

endmodule : dff_rv_bit

`default_nettype wire

// File: rtl/dff_rv.sv
// ============================================================================
// Module : dff_rv
// Brief  : WIDTH-bit D register with synchronous reset to RESET_VAL and
//          capture enable. Macro DFF_RV_SCAN_EN adds a shift-left scan chain.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module dff_rv
    import dff_rv_pkg::*;
#(
    parameter int unsigned WIDTH     = 1,
    parameter dff_rv_val_t RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
`ifdef DFF_RV_SCAN_EN
    input  logic             scan_en_i,
    input  logic             scan_i,
`endif
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    genvar i;

    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
`ifdef DFF_RV_SCAN_EN
            logic w_scan_in;

            // Bit 0 takes the serial input, every other bit its lower neighbour.
            if (i == 0) begin : g_scan_head
                assign w_scan_in = scan_i;
            end else begin : g_scan_link
                assign w_scan_in = data_o[i-1];
            end
`endif

            dff_rv_bit #(
                .RESET_VAL (RESET_VAL[i])
            ) u_bit (
                .clk_i     (clk_i),
                .reset_i   (reset_i),
                .en_i      (en_i),
                .d_i       (data_i[i]),
`ifdef DFF_RV_SCAN_EN
                .scan_en_i (scan_en_i),
                .q_i       (w_scan_in),
`endif
                .q_o       (data_o[i])
            );
        end
    endgenerate

endmodule : dff_rv

`default_nettype wire

// File: tb/tb_dff_rv.sv
// ============================================================================
// Module : tb_dff_rv
// Brief  : Directed self-checking bench for dff_rv (single bit, ring of eight,
//          8-bit enable/reset cases, optional scan with DFF_RV_SCAN_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_dff_rv;

    logic clk = 1'b0;
    always #1 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Single bit, RESET_VAL = 1
    logic r_rst1 = 1'b1, r_en1 = 1'b1, r_d1 = 1'b0;
    logic w_q1;

    // Ring of eight 1-bit cells
    logic       r_rst_ring = 1'b1;
    logic [7:0] w_ring;

    // 8-bit, RESET_VAL = A5
    logic       r_rst8 = 1'b1, r_en8 = 1'b0;
    logic [7:0] r_d8 = 8'h00;
    logic [7:0] w_q8;

    // 8-bit, RESET_VAL = FF
    logic       r_rstf = 1'b1, r_enf = 1'b0;
    logic [7:0] r_df = 8'h00;
    logic [7:0] w_qf;

`ifdef DFF_RV_SCAN_EN
    logic       r_rst4 = 1'b1, r_en4 = 1'b0, r_sen4 = 1'b0, r_si4 = 1'b0;
    logic [3:0] r_d4 = 4'h0;
    logic [3:0] w_q4;
`endif

    dff_rv #(.WIDTH(1), .RESET_VAL(64'h1)) u_dut1 (
        .clk_i(clk), .reset_i(r_rst1), .en_i(r_en1),
`ifdef DFF_RV_SCAN_EN
        .scan_en_i(1'b0), .scan_i(1'b0),
`endif
        .data_i(r_d1), .data_o(w_q1)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ring
            dff_rv #(.WIDTH(1), .RESET_VAL(64'(gi % 2))) u_cell (
                .clk_i(clk), .reset_i(r_rst_ring), .en_i(1'b1),
`ifdef DFF_RV_SCAN_EN
                .scan_en_i(1'b0), .scan_i(1'b0),
`endif
                .data_i(w_ring[(gi+7)%8]), .data_o(w_ring[gi])
            );
        end
    endgenerate

    dff_rv #(.WIDTH(8), .RESET_VAL(64'hA5)) u_dut8 (
        .clk_i(clk), .reset_i(r_rst8), .en_i(r_en8),
`ifdef DFF_RV_SCAN_EN
        .scan_en_i(1'b0), .scan_i(1'b0),
`endif
        .data_i(r_d8), .data_o(w_q8)
    );

    dff_rv #(.WIDTH(8), .RESET_VAL(64'hFF)) u_dutf (
        .clk_i(clk), .reset_i(r_rstf), .en_i(r_enf),
`ifdef DFF_RV_SCAN_EN
        .scan_en_i(1'b0), .scan_i(1'b0),
`endif
        .data_i(r_df), .data_o(w_qf)
    );

`ifdef DFF_RV_SCAN_EN
    dff_rv #(.WIDTH(4), .RESET_VAL(64'h0)) u_dut4 (
        .clk_i(clk), .reset_i(r_rst4), .en_i(r_en4),
        .scan_en_i(r_sen4), .scan_i(r_si4),
        .data_i(r_d4), .data_o(w_q4)
    );
`endif

    // Advance one rising edge, then settle half a phase before sampling/driving.
    task automatic step();
        @(posedge clk);
        #0.5;
    endtask

    task automatic test_ring();
        logic [7:0] exp;
        #6.6;
        r_rst_ring = 1'b0;
        exp = 8'b1010_1010;
        n_cmp++;
        if (w_ring !== exp) begin
            n_fail++;
            $display("FAIL ring_reset: got %b expected %b", w_ring, exp);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            exp = {exp[6:0], exp[7]};
            n_cmp++;
            if (w_ring !== exp) begin
                n_fail++;
                $display("FAIL ring_rotate[%0d]: got %b expected %b", k, w_ring, exp);
            end
        end
    endtask

    task automatic test_reset();
        r_rst1 = 1'b1; r_en1 = 1'b1; r_d1 = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (w_q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_reset: got %b expected 1", w_q1);
        end
        r_rst1 = 1'b0;
        step();
        n_cmp++;
        if (w_q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_release: got %b expected 0", w_q1);
        end
        r_d1 = 1'b1;
        step();
        n_cmp++;
        if (w_q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_capture: got %b expected 1", w_q1);
        end
        r_en1 = 1'b0; r_d1 = 1'b0;
        step();
        n_cmp++;
        if (w_q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_hold: got %b expected 1", w_q1);
        end
    endtask

    task automatic test_enable();
        r_rst8 = 1'b1; r_en8 = 1'b0; r_d8 = 8'h00;
        step();
        n_cmp++;
        if (w_q8 !== 8'hA5) begin
            n_fail++;
            $display("FAIL w8_reset: got %h expected a5", w_q8);
        end
        r_rst8 = 1'b0; r_en8 = 1'b1; r_d8 = 8'h3C;
        step();
        n_cmp++;
        if (w_q8 !== 8'h3C) begin
            n_fail++;
            $display("FAIL w8_capture: got %h expected 3c", w_q8);
        end
        r_en8 = 1'b0; r_d8 = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (w_q8 !== 8'h3C) begin
                n_fail++;
                $display("FAIL w8_hold[%0d]: got %h expected 3c", k, w_q8);
            end
        end
    endtask

    task automatic test_reset_mid();
        r_rst8 = 1'b1; r_en8 = 1'b1; r_d8 = 8'h77;
        step();
        n_cmp++;
        if (w_q8 !== 8'hA5) begin
            n_fail++;
            $display("FAIL w8_mid_reset: got %h expected a5", w_q8);
        end
        r_rst8 = 1'b0; r_d8 = 8'h5A;
        step();
        n_cmp++;
        if (w_q8 !== 8'h5A) begin
            n_fail++;
            $display("FAIL w8_post_reset_capture: got %h expected 5a", w_q8);
        end
    endtask

    task automatic test_reset_priority();
        r_rstf = 1'b0; r_enf = 1'b1; r_df = 8'h00;
        step();
        n_cmp++;
        if (w_qf !== 8'h00) begin
            n_fail++;
            $display("FAIL wf_preload: got %h expected 00", w_qf);
        end
        r_rstf = 1'b1; r_enf = 1'b1; r_df = 8'h00;
        step();
        n_cmp++;
        if (w_qf !== 8'hFF) begin
            n_fail++;
            $display("FAIL wf_reset_over_en: got %h expected ff", w_qf);
        end
        r_rstf = 1'b0; r_df = 8'h81;
        step();
        n_cmp++;
        if (w_qf !== 8'h81) begin
            n_fail++;
            $display("FAIL wf_release_capture: got %h expected 81", w_qf);
        end
    endtask

`ifdef DFF_RV_SCAN_EN
    task automatic test_scan();
        logic [3:0] seq_bits;
        logic [3:0] exp_q [4];
        seq_bits = 4'b1101;  // applied LSB first: 1,0,1,1
        exp_q[0] = 4'b0001; exp_q[1] = 4'b0010;
        exp_q[2] = 4'b0101; exp_q[3] = 4'b1011;
        r_rst4 = 1'b1; r_sen4 = 1'b0; r_en4 = 1'b1; r_d4 = 4'hF;
        step();
        n_cmp++;
        if (w_q4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL scan_reset: got %b expected 0000", w_q4);
        end
        r_rst4 = 1'b0; r_sen4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r_si4 = seq_bits[k];
            step();
            n_cmp++;
            if (w_q4 !== exp_q[k]) begin
                n_fail++;
                $display("FAIL scan_shift[%0d]: got %b expected %b", k, w_q4, exp_q[k]);
            end
        end
        r_rst4 = 1'b1; r_si4 = 1'b1;
        step();
        n_cmp++;
        if (w_q4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL scan_reset_priority: got %b expected 0000", w_q4);
        end
    endtask
`endif

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete within 20000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_ring();
        test_reset();
        test_enable();
        test_reset_mid();
        test_reset_priority();
`ifdef DFF_RV_SCAN_EN
        test_scan();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dff_rv

`default_nettype wire
